// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Sequences one command at a time through an external combinational ALU.
// The accepted command is registered onto the ALU drive, given SETTLE_CYCLES
// clock edges to settle, then the ALU result and flags are captured into the
// response registers. The response is held until the consumer takes it.
// A divide by zero bypasses the ALU and responds on the next edge with a
// fixed error response.
//
// Parameters
//   SETTLE_CYCLES  1..15  edges between accept and result capture
//
// Ports
//   Clk          sole clock, rising edge
//   Reset        asynchronous, active-high reset
//   CmdValid     command request
//   CmdReady     command accept (only while idle)
//   CmdOpcode    4-bit ALU opcode
//   CmdOp1/2     8-bit operands
//   AluOperand1/2, AluOpcode   registered drive to the external ALU
//   AluResult, AluFlagC, AluFlagZ   combinational ALU outputs
//   RspValid     response available
//   RspReady     response consumed
//   RspResult, RspFlagC, RspFlagZ, RspDivErr   captured response
//   OpCount      count of completed responses, wraps at 16 bits
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [3:0]  CmdOpcode,
  input  logic [7:0]  CmdOp1,
  input  logic [7:0]  CmdOp2,
  output logic [7:0]  AluOperand1,
  output logic [7:0]  AluOperand2,
  output logic [3:0]  AluOpcode,
  input  logic [15:0] AluResult,
  input  logic        AluFlagC,
  input  logic        AluFlagZ,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [15:0] RspResult,
  output logic        RspFlagC,
  output logic        RspFlagZ,
  output logic        RspDivErr,
  output logic [15:0] OpCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_DIV      = 4'b0011;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  settle_cnt_reg;
  logic [3:0]  alu_opcode_reg;
  logic [7:0]  alu_op1_reg;
  logic [7:0]  alu_op2_reg;
  logic [15:0] rsp_result_reg;
  logic        rsp_flag_c_reg;
  logic        rsp_flag_z_reg;
  logic        rsp_div_err_reg;
  logic [15:0] op_count_reg;

  // Decoded control strobes from the next-state logic
  logic        idle_ready;
  logic        accept;
  logic        div_zero;
  logic        settle_tick;
  logic        capture;
  logic        rsp_done;
  logic        carry_kept;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    idle_ready  = 1'b0;
    accept      = 1'b0;
    div_zero    = 1'b0;
    settle_tick = 1'b0;
    capture     = 1'b0;
    rsp_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        idle_ready = 1'b1;
        if (CmdValid) begin
          accept = 1'b1;
          // Divide by zero never reaches the ALU result; answer immediately
          if ((CmdOpcode == OP_DIV) && (CmdOp2 == 8'h00)) begin
            div_zero   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        settle_tick = 1'b1;
        // Counter steps from 1 to 0 on this edge: the ALU has settled
        if (settle_cnt_reg <= 4'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (RspReady) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Carry is only meaningful for add and subtract
  assign carry_kept = ((alu_opcode_reg == OP_ADD) || (alu_opcode_reg == OP_SUB))
                      ? AluFlagC : 1'b0;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      settle_cnt_reg  <= 4'd0;
      alu_opcode_reg  <= 4'd0;
      alu_op1_reg     <= 8'd0;
      alu_op2_reg     <= 8'd0;
      rsp_result_reg  <= 16'd0;
      rsp_flag_c_reg  <= 1'b0;
      rsp_flag_z_reg  <= 1'b0;
      rsp_div_err_reg <= 1'b0;
      op_count_reg    <= 16'd0;
    end else begin
      if (accept) begin
        alu_opcode_reg <= CmdOpcode;
        alu_op1_reg    <= CmdOp1;
        alu_op2_reg    <= CmdOp2;
        settle_cnt_reg <= SETTLE_LOAD;
      end else if (settle_tick && (settle_cnt_reg != 4'd0)) begin
        settle_cnt_reg <= settle_cnt_reg - 4'd1;
      end

      if (div_zero) begin
        rsp_result_reg  <= 16'd0;
        rsp_flag_c_reg  <= 1'b0;
        rsp_flag_z_reg  <= 1'b1;
        rsp_div_err_reg <= 1'b1;
      end else if (capture) begin
        rsp_result_reg  <= AluResult;
        rsp_flag_c_reg  <= carry_kept;
        rsp_flag_z_reg  <= AluFlagZ;
        rsp_div_err_reg <= 1'b0;
      end

      if (rsp_done) begin
        op_count_reg <= op_count_reg + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Masked by Reset so the request side reads not-ready throughout reset
  assign CmdReady    = idle_ready & ~Reset;
  assign RspValid    = (state_reg == RESP);
  assign AluOpcode   = alu_opcode_reg;
  assign AluOperand1 = alu_op1_reg;
  assign AluOperand2 = alu_op2_reg;
  assign RspResult   = rsp_result_reg;
  assign RspFlagC    = rsp_flag_c_reg;
  assign RspFlagZ    = rsp_flag_z_reg;
  assign RspDivErr   = rsp_div_err_reg;
  assign OpCount     = op_count_reg;

endmodule
